// File: rtl/pes_vm_change_dispenser.sv
// Change dispenser: queues vend change requests and hands out 5-unit coins one hopper handshake at a time.
// Optional hopper-ack timeout is compiled in with PES_VM_CHG_TIMEOUT_EN.
module pes_vm_change_dispenser #(
  parameter int DEPTH          = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       out,
  input  logic [1:0] change,
  output logic       hopper_req,
  input  logic       hopper_ack,
  output logic       busy,
  output logic [3:0] pending,
  output logic       overflow,
  output logic       illegal,
  output logic       fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(GAP_CYCLES) + 1;

  if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("GAP_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, LOAD, REQ, GAP} state_t;
  state_t state, state_n;

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [1:0]    coins;
  logic [GW-1:0] gcnt;
  logic          push, push_ok, pop, full, empty, ack_take, timeout;
  logic [3:0]    add, sub;

  assign push     = out && (change == 2'd1 || change == 2'd2);
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop      = (state == LOAD);
  // A full queue still accepts when the head leaves on the same edge.
  assign push_ok  = push && (!full || pop);
  assign ack_take = (state == REQ) && hopper_ack;

`ifdef PES_VM_CHG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tcnt;

  assign timeout = (state == REQ) && !hopper_ack && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // Held at zero outside REQ, so every entry into REQ starts a fresh count.
  always_ff @(posedge clock) begin
    if (reset) begin
      tcnt  <= '0;
      fault <= 1'b0;
    end else begin
      tcnt <= (state == REQ) ? tcnt + 1'b1 : '0;
      if (timeout) fault <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (!empty) state_n = LOAD;
      LOAD: state_n = REQ;
      REQ: begin
        if (ack_take)     state_n = GAP;
        else if (timeout) state_n = IDLE;
      end
      GAP: if (gcnt == '0) state_n = (coins != 2'd0) ? REQ : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    add = push_ok ? {2'b00, change} : 4'd0;
    sub = 4'd0;
    if (ack_take)     sub = 4'd1;
    else if (timeout) sub = {2'b00, coins};
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wptr] <= change;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      hopper_req <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      coins      <= 2'd0;
      gcnt       <= '0;
      pending    <= 4'd0;
      overflow   <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      state      <= state_n;
      hopper_req <= (state_n == REQ);
      illegal    <= out && (change == 2'd3);
      pending    <= pending + add - sub;
      if (push && !push_ok) overflow <= 1'b1;
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop)           coins <= mem[rptr];
      else if (ack_take) coins <= coins - 1'b1;
      else if (timeout)  coins <= 2'd0;
      if (ack_take)                      gcnt <= GW'(GAP_CYCLES - 1);
      else if (state == GAP && gcnt != '0) gcnt <= gcnt - 1'b1;
    end
  end

  assign busy = (pending != 4'd0) || (state != IDLE);

endmodule

// File: tb/tb_pes_vm_change_dispenser.sv
// Bench for pes_vm_change_dispenser: directed scenarios then random traffic against a
// timeline model (absolute cycle numbers for pops, hopper requests and idle points).
module tb_pes_vm_change_dispenser;

  localparam int DEPTH = 4;
  localparam int GAP   = 2;
  localparam int TO    = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       out = 1'b0;
  logic [1:0] change = 2'd0;
  logic       hopper_ack = 1'b0;
  logic       hopper_req, busy, overflow, illegal, fault;
  logic [3:0] pending;

  int vectors = 0;
  int miscompares = 0;

  pes_vm_change_dispenser #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .out(out), .change(change),
    .hopper_req(hopper_req), .hopper_ack(hopper_ack), .busy(busy),
    .pending(pending), .overflow(overflow), .illegal(illegal), .fault(fault)
  );

  always #5 clock = ~clock;

  // Model: cycle n is the interval after rising edge n.
  int q[$];
  int cur, req_at, pop_at, free_at, cyc;
  bit m_ovf, m_fault, m_ill;

  function automatic int m_pend();
    int s = cur;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  function automatic bit m_req();
    return (cur > 0) && (req_at >= 0) && (cyc >= req_at);
  endfunction

  function automatic bit m_busy();
    return (m_pend() != 0) || !(cur == 0 && pop_at < 0 && cyc >= free_at);
  endfunction

  task automatic model_clear();
    q.delete();
    cur = 0; req_at = -1; pop_at = -1; free_at = cyc;
    m_ovf = 0; m_fault = 0; m_ill = 0;
  endtask

  task automatic model_edge(input bit o, input logic [1:0] c, input bit a);
    bit req_now = m_req();
    bit pop     = (pop_at == cyc + 1);
    bit examine = (cur == 0) && (pop_at < 0) && (cyc >= free_at) && (q.size() > 0);
    int size_before = q.size();
    m_ill = o && (c == 2'd3);
    if (req_now && a) begin
      cur--;
      if (cur > 0) req_at = cyc + 1 + GAP;
      else begin req_at = -1; free_at = cyc + 1 + GAP; end
    end
`ifdef PES_VM_CHG_TIMEOUT_EN
    else if (req_now && (cyc - req_at + 1 >= TO)) begin
      cur = 0; m_fault = 1; req_at = -1; free_at = cyc + 1;
    end
`endif
    if (examine) pop_at = cyc + 2;
    if (pop) begin
      cur = q.pop_front(); req_at = cyc + 1; pop_at = -1;
    end
    if (o && (c == 2'd1 || c == 2'd2)) begin
      if (size_before < DEPTH || pop) q.push_back(int'(c));
      else m_ovf = 1;
    end
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("hopper_req", 8'(hopper_req), 8'(m_req()));
    chk("pending",    8'(pending),    8'(m_pend()));
    chk("busy",       8'(busy),       8'(m_busy()));
    chk("overflow",   8'(overflow),   8'(m_ovf));
    chk("illegal",    8'(illegal),    8'(m_ill));
    chk("fault",      8'(fault),      8'(m_fault));
  endtask

  task automatic step(input bit o, input logic [1:0] c, input bit a);
    @(negedge clock);
    check_all();
    reset = 1'b0; out = o; change = c; hopper_ack = a;
    @(posedge clock);
    model_edge(o, c, a);
  endtask

  // Inputs are randomized during reset, including ack, which must be ignored.
  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      reset = 1'b1; out = 1'($urandom_range(1)); change = 2'($urandom_range(3));
      hopper_ack = 1'($urandom_range(1));
      @(posedge clock);
      cyc++;
    end
    model_clear();
  endtask

  initial begin
    cyc = 0;
    model_clear();
    do_reset(2);
    @(negedge clock);
    chk("rst_req", 8'(hopper_req), 8'd0);
    chk("rst_pending", 8'(pending), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_overflow", 8'(overflow), 8'd0);

    // Single coin: latency, one handshake, busy drops after the gap.
    step(1, 2'd1, 0);
    #1 chk("lat_pending", 8'(pending), 8'd1);
    chk("lat_req_early", 8'(hopper_req), 8'd0);
    step(0, 2'd0, 0);
    step(0, 2'd0, 0);
    #1 chk("latency_req", 8'(hopper_req), 8'd1);
    step(0, 2'd0, 0);
    step(0, 2'd0, 1);
    #1 chk("one_pending", 8'(pending), 8'd0);
    chk("one_req_drop", 8'(hopper_req), 8'd0);
    step(0, 2'd0, 0);
    step(0, 2'd0, 0);
    #1 chk("one_busy", 8'(busy), 8'd0);

    // Two coins, ack on the second REQ cycle each time.
    step(1, 2'd2, 0);
    step(0, 2'd0, 0); step(0, 2'd0, 0); step(0, 2'd0, 0);
    step(0, 2'd0, 1);
    #1 chk("two_pending1", 8'(pending), 8'd1);
    step(0, 2'd0, 0); step(0, 2'd0, 0);
    #1 chk("two_gap_req", 8'(hopper_req), 8'd1);
    step(0, 2'd0, 0);
    step(0, 2'd0, 1);
    #1 chk("two_pending0", 8'(pending), 8'd0);
    repeat (3) step(0, 2'd0, 0);

    // Illegal code.
    step(1, 2'd3, 0);
    #1 chk("ill_pulse", 8'(illegal), 8'd1);
    chk("ill_pending", 8'(pending), 8'd0);
    step(0, 2'd0, 0);
    #1 chk("ill_clear", 8'(illegal), 8'd0);
    chk("ill_req", 8'(hopper_req), 8'd0);
    step(1, 2'd0, 0);
    step(0, 2'd2, 0);
    #1 chk("ignored_pending", 8'(pending), 8'd0);

    // Overflow: six back-to-back two-coin requests, no ack.
    do_reset(1);
    repeat (6) step(1, 2'd2, 0);
    #1 chk("ovf_pending", 8'(pending), 8'd10);
    chk("ovf_flag", 8'(overflow), 8'd1);
    step(0, 2'd0, 0);
    step(0, 2'd0, 0);

    // Reset in REQ with an ack during reset discards everything.
    do_reset(1);
    step(0, 2'd0, 0);

`ifdef PES_VM_CHG_TIMEOUT_EN
    step(1, 2'd2, 0);
    repeat (18) step(0, 2'd0, 0);
    #1 chk("to_fault", 8'(fault), 8'd1);
    chk("to_pending", 8'(pending), 8'd0);
    chk("to_req", 8'(hopper_req), 8'd0);
    do_reset(1);
    step(1, 2'd1, 0);
    step(0, 2'd0, 0); step(0, 2'd0, 0);
    step(0, 2'd0, 1);
    repeat (3) step(0, 2'd0, 0);
    #1 chk("to_after_fault", 8'(fault), 8'd0);
    chk("to_after_busy", 8'(busy), 8'd0);
`endif

    // Random traffic with occasional mid-operation resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(79) == 0) do_reset(1);
      else step(($urandom_range(2) == 0), 2'($urandom_range(3)), 1'($urandom_range(1)));
    end
    step(0, 2'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
